// File: rtl/seq_det_sched_pkg.sv
// Shared constants, FSM encodings and the round-robin pick function for seq_det_sched.
package seq_det_sched_pkg;

  localparam int unsigned DEF_NREQ   = 4;
  localparam int unsigned DEF_WORD_W = 8;
  localparam int unsigned DEF_ID_W   = 2;
  localparam int unsigned DEF_CNT_W  = 5;

  localparam int unsigned MAX_NREQ  = 8;
  localparam int unsigned MAX_IDX_W = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  // First set request strictly after 'last', wrapping modulo nreq.
  function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] req,
                                          input int unsigned         last,
                                          input int unsigned         nreq);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
      idx = (last + k) % nreq;
      if (!found && (k <= nreq) && req[idx[MAX_IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Requester arbiter: combinational one-hot pick plus the registered last-grant pointer.
// SEQ_DET_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority and drops the pointer.
module rr_arbiter
  import seq_det_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned ID_W = DEF_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic take;
  assign take = en && (|req);

`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Searching from NREQ-1 always yields the lowest set index.
  always_comb begin
    gnt_idx = ID_W'(rr_pick(MAX_NREQ'(req), NREQ - 1, NREQ));
  end
`else
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] last_d;

  always_comb begin
    gnt_idx = ID_W'(rr_pick(MAX_NREQ'(req), 32'(last_q), NREQ));
    last_d  = last_q;
    if (take) begin
      last_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_W'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (take) begin
      gnt = NREQ'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one bit-serial sequence detector between NREQ requesters: grant, clear, shift MSB-first, report.
// Optional macro SEQ_DET_SCHED_FIXED_PRIO_EN switches the arbiter to fixed priority.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int unsigned NREQ   = DEF_NREQ,
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned ID_W   = DEF_ID_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] req_word,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   det_clr,
  output logic                   det_x,
  input  logic                   det_y,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   done_hit
);

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic              det_x_q, det_x_d;
  logic              det_clr_q, det_clr_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic              done_hit_q, done_hit_d;
  logic              busy_q, busy_d;

  logic                         arb_en;
  logic [NREQ-1:0]              arb_gnt;
  logic [ID_W-1:0]              arb_idx;
  logic [NREQ-1:0][WORD_W-1:0]  words;
  logic [WORD_W-1:0]            sel_word;

  assign arb_en   = (state_q == S_IDLE);
  assign words    = req_word;
  assign sel_word = words[arb_idx];

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req     (req),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // word_q doubles as the shift register; det_x is pre-loaded one state ahead so it is registered.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    hit_d      = hit_q;
    det_x_d    = 1'b0;
    det_clr_d  = 1'b0;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    done_hit_d = done_hit_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          word_d    = sel_word;
          id_d      = arb_idx;
          det_clr_d = 1'b1;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        hit_d   = 1'b0;
        det_x_d = word_q[WORD_W-1];
        word_d  = {word_q[WORD_W-2:0], 1'b0};
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d  = cnt_q + CNT_W'(1);
        word_d = {word_q[WORD_W-2:0], 1'b0};
        // The first det_y of a job still reflects the clear.
        if (cnt_q != '0) begin
          hit_d = hit_q | det_y;
        end
        if (cnt_q == CNT_W'(WORD_W - 1)) begin
          state_d = S_DRAIN;
        end else begin
          det_x_d = word_q[WORD_W-1];
        end
      end
      S_DRAIN: begin
        hit_d      = hit_q | det_y;
        done_d     = 1'b1;
        done_id_d  = id_q;
        done_hit_d = hit_q | det_y;
        state_d    = S_REPORT;
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      det_x_q    <= 1'b0;
      det_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      done_hit_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      det_x_q    <= det_x_d;
      det_clr_q  <= det_clr_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      done_hit_q <= done_hit_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = arb_gnt;
  assign busy     = busy_q;
  assign det_clr  = det_clr_q;
  assign det_x    = det_x_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign done_hit = done_hit_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: scoreboard of expected (id, hit) results, bench-driven detector stub.
module tb_seq_det_sched;

  localparam int NREQ   = 4;
  localparam int WORD_W = 8;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WORD_W-1:0] req_word = '0;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   det_clr;
  logic                   det_x;
  logic                   det_y = 1'b0;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic                   done_hit;

  always #5 clk = ~clk;

  seq_det_sched #(
    .NREQ   (NREQ),
    .WORD_W (WORD_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_word (req_word),
    .gnt      (gnt),
    .busy     (busy),
    .det_clr  (det_clr),
    .det_x    (det_x),
    .det_y    (det_y),
    .done     (done),
    .done_id  (done_id),
    .done_hit (done_hit)
  );

  typedef struct {
    int   id;
    logic hit;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_last = NREQ - 1;

  // Reference pick: round-robin after 'last', or lowest index under fixed priority.
  function automatic int exp_pick(logic [NREQ-1:0] r, int last);
    int p;
    int idx;
    p = -1;
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
    last = NREQ - 1;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (p < 0 && r[idx]) p = idx;
    end
    return p;
  endfunction

  // Scoreboard: every done strobe must match the oldest outstanding expected result.
  always @(negedge clk) begin
    res_t e;
    #2;
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done id=%0d hit=%0b, none expected", done_id, done_hit);
      end else begin
        e = exp_q.pop_front();
        if (done_id !== ID_W'(e.id) || done_hit !== e.hit) begin
          errors++;
          $display("FAIL done_result: got id=%0d hit=%0b, expected id=%0d hit=%0b", done_id, done_hit, e.id, e.hit);
        end
      end
    end
    if (gnt !== '0) begin
      checks++;
      if (busy !== 1'b0 || !$onehot(gnt)) begin
        errors++;
        $display("FAIL gnt_legal: gnt=%b busy=%b, expected one-hot gnt with busy=0", gnt, busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    req   = '0;
    det_y = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_last = NREQ - 1;
  endtask

  // Stimulus only: plays the detector stub for one job starting at the grant cycle and records observations.
  task automatic run_job(input logic [11:0] ypat, input logic [NREQ-1:0] drop, input logic [NREQ-1:0] pulse,
                         output logic [WORD_W-1:0] xbits, output logic clr_seen, output int done_k,
                         output logic hit_at, output logic [NREQ-1:0] gnt_acc);
    xbits    = '0;
    clr_seen = 1'b0;
    done_k   = 0;
    hit_at   = 1'b0;
    gnt_acc  = '0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      det_y = ypat[k];
      if (k == 1) req = req & ~drop;
      if (k == 3) req = req | pulse;
      if (k == 7) req = req & ~pulse;
      #1;
      if (k == 1) clr_seen = det_clr;
      if (k >= 2 && k <= 9) xbits[9-k] = det_x;
      gnt_acc = gnt_acc | gnt;
      if (done && done_k == 0) begin
        done_k = k;
        hit_at = done_hit;
      end
    end
    det_y = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({gnt, busy, det_clr, det_x, done, done_hit} !== '0 || done_id !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b busy=%b clr=%b x=%b done=%b id=%0d hit=%b, expected all 0",
               gnt, busy, det_clr, det_x, done, done_id, done_hit);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b gnt=%b, expected 0 0", busy, gnt);
    end
  endtask

  task automatic test_single_job();
    logic [WORD_W-1:0] xb;
    logic              clr;
    logic              hit;
    int                dk;
    logic [NREQ-1:0]   ga;
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    req_word[2*WORD_W +: WORD_W] = 8'hA5;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL single_gnt: got %b, expected 0100", gnt);
    end
    m_last = 2;
    exp_q.push_back('{id: 2, hit: 1'b0});
    run_job(12'h000, 4'b0100, 4'b0000, xb, clr, dk, hit, ga);
    checks++;
    if (clr !== 1'b1) begin
      errors++;
      $display("FAIL single_clr: det_clr at T+1 got %b, expected 1", clr);
    end
    checks++;
    if (xb !== 8'hA5) begin
      errors++;
      $display("FAIL single_bits: det_x sequence got %h, expected a5", xb);
    end
    checks++;
    if (dk !== 11 || hit !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done at T+%0d hit=%b, expected T+11 hit=0", dk, hit);
    end
  endtask

  task automatic test_hit_capture();
    logic [WORD_W-1:0] xb;
    logic              clr;
    logic              hit;
    int                dk;
    logic [NREQ-1:0]   ga;
    int                yk[3]   = '{2, 8, 10};
    logic              exph[3] = '{1'b0, 1'b1, 1'b1};
    logic [11:0]       pat;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      req = 4'b0001;
      req_word[0 +: WORD_W] = 8'hC3;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("FAIL hit_gnt%0d: got %b, expected 0001", j, gnt);
      end
      m_last = 0;
      exp_q.push_back('{id: 0, hit: exph[j]});
      pat = 12'h001 << yk[j];
      run_job(pat, 4'b0001, 4'b0000, xb, clr, dk, hit, ga);
      checks++;
      if (dk !== 11 || hit !== exph[j]) begin
        errors++;
        $display("FAIL hit_case%0d: done at T+%0d hit=%b, expected T+11 hit=%b", j, dk, hit, exph[j]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || done_id !== 2'd0 || done_hit !== 1'b1) begin
        errors++;
        $display("FAIL hit_hold: done=%b id=%0d hit=%b, expected 0 0 1", done, done_id, done_hit);
      end
    end
  endtask

  task automatic test_grants(input string name, input logic [NREQ-1:0] rq, input int n_jobs);
    logic [WORD_W-1:0] xb;
    logic              clr;
    logic              hit;
    int                dk;
    logic [NREQ-1:0]   ga;
    int                e;
    logic [NREQ-1:0]   eg;
    do_reset();
    @(negedge clk);
    req = rq;
    for (int i = 0; i < NREQ; i++) req_word[i*WORD_W +: WORD_W] = 8'(8'h11 * (i + 1));
    #1;
    for (int n = 0; n < n_jobs; n++) begin
      e      = exp_pick(req, m_last);
      m_last = e;
      eg     = 4'b0001 << e;
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL %s_gnt%0d: got %b, expected %b", name, n, gnt, eg);
      end
      exp_q.push_back('{id: e, hit: 1'b0});
      run_job(12'h000, 4'b0000, 4'b0000, xb, clr, dk, hit, ga);
      checks++;
      if (dk !== 11 || xb !== 8'(8'h11 * (e + 1))) begin
        errors++;
        $display("FAIL %s_job%0d: done at T+%0d bits=%h, expected T+11 bits=%h", name, n, dk, xb, 8'(8'h11 * (e + 1)));
      end
      if (n < n_jobs - 1) begin
        @(negedge clk);
        #1;
      end
    end
    req = '0;
  endtask

  task automatic test_drop_before_grant();
    logic [WORD_W-1:0] xb;
    logic              clr;
    logic              hit;
    int                dk;
    logic [NREQ-1:0]   ga;
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    req_word[0 +: WORD_W] = 8'h5A;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL drop_first_gnt: got %b, expected 0001", gnt);
    end
    m_last = 0;
    exp_q.push_back('{id: 0, hit: 1'b0});
    run_job(12'h000, 4'b0001, 4'b0010, xb, clr, dk, hit, ga);
    checks++;
    if (ga !== 4'b0000 || dk !== 11) begin
      errors++;
      $display("FAIL drop_busy: gnt while busy=%b done at T+%0d, expected 0000 T+11", ga, dk);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drop_after: gnt=%b busy=%b, expected 0000 0", gnt, busy);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [WORD_W-1:0] xb;
    logic              clr;
    logic              hit;
    int                dk;
    logic [NREQ-1:0]   ga;
    int                e;
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    req_word[2*WORD_W +: WORD_W] = 8'hA5;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_gnt: got %b, expected 0100", gnt);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst    = 1'b0;
    m_last = NREQ - 1;
    req    = 4'b1111;
    #1;
    checks++;
    if (busy !== 1'b0 || det_x !== 1'b0 || done !== 1'b0 || det_clr !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: busy=%b x=%b done=%b clr=%b, expected 0 0 0 0", busy, det_x, done, det_clr);
    end
    e      = exp_pick(req, m_last);
    m_last = e;
    checks++;
    if (gnt !== 4'b0001 || e != 0) begin
      errors++;
      $display("FAIL rstmid_regrant: got %b, expected 0001", gnt);
    end
    exp_q.push_back('{id: 0, hit: 1'b0});
    run_job(12'h000, 4'b1111, 4'b0000, xb, clr, dk, hit, ga);
    checks++;
    if (dk !== 11) begin
      errors++;
      $display("FAIL rstmid_done: done at T+%0d, expected T+11", dk);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_hit_capture();
    test_grants("rr", 4'b1111, 5);
    test_grants("wrap", 4'b1001, 3);
    test_drop_before_grant();
    test_reset_mid_shift();
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
